// File: rtl/player_ship_object_if.sv
// Pixel-scan, move-command and draw-output bundle between the video unit and the
// player ship object. The video unit holds the master side; the ship object holds the slave side.
interface player_ship_object_if;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        move_left;
  logic        move_right;
  logic        draw_request;
  logic [7:0]  RGBout;
  logic [10:0] ship_x;

  modport master (
    output pixelX, pixelY, startOfFrame, move_left, move_right,
    input  draw_request, RGBout, ship_x
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame, move_left, move_right,
    output draw_request, RGBout, ship_x
  );
endinterface

// File: rtl/player_ship_object.sv
// Player ship drawing stage: per-frame horizontal movement with clamping, plus a
// two-stage pixel pipeline producing a registered draw request and RGB value.
module player_ship_object #(
  parameter int unsigned OBJECT_WIDTH  = 32,
  parameter int unsigned OBJECT_HEIGHT = 32,
  parameter int unsigned INITIAL_X     = 304,
  parameter int unsigned INITIAL_Y     = 440,
  parameter int unsigned X_SPEED       = 2,
  parameter int unsigned X_MIN         = 0,
  parameter int unsigned X_MAX         = 608,
  parameter logic [7:0]  SHIP_RGB      = 8'h1C,
  // Row 0 first; within a row, bit index = column (column 0 is the rightmost digit).
  parameter logic [0:15][15:0] SHIP_BITMAP = {
    16'h8001, 16'h8181, 16'h83C1, 16'h87E1,
    16'h8FF1, 16'h9FF9, 16'hBFFD, 16'hFFFF,
    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
    16'hE7E7, 16'hC3C3, 16'h8181, 16'h8001
  }
) (
  input logic                 clk,
  input logic                 resetN,
  player_ship_object_if.slave bus
);

  logic [10:0] r_top_left_x;
  logic [10:0] w_next_x;
  logic [11:0] w_sub;
  logic [11:0] w_add;

  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic        w_inside;

  logic        r_inside;
  logic [3:0]  r_off_x;
  logic [3:0]  r_off_y;
  logic        w_opaque;

  logic        r_draw_request;
  logic [7:0]  r_rgb;

  // Widening to 12 bits lets bit 11 flag an underflow instead of wrapping to a large X.
  assign w_sub = {1'b0, r_top_left_x} - 12'(X_SPEED);
  assign w_add = {1'b0, r_top_left_x} + 12'(X_SPEED);

  // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    w_next_x = r_top_left_x;
    if (bus.startOfFrame) begin
      if (bus.move_left && !bus.move_right) begin
        if ($signed(w_sub) < $signed(12'(X_MIN)))
          w_next_x = 11'(X_MIN);
        else
          w_next_x = w_sub[10:0];
      end else if (bus.move_right && !bus.move_left) begin
        if (w_add > 12'(X_MAX))
          w_next_x = 11'(X_MAX);
        else
          w_next_x = w_add[10:0];
      end
    end
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous and active-high here.
  always_ff @(posedge clk) begin
    if (resetN)
      r_top_left_x <= 11'(INITIAL_X);
    else
      r_top_left_x <= w_next_x;
  end

  // Left/above the box wraps to a large unsigned value and therefore fails the range test.
  assign w_dx     = bus.pixelX - r_top_left_x;
  assign w_dy     = bus.pixelY - 11'(INITIAL_Y);
  assign w_inside = (w_dx < 11'(OBJECT_WIDTH)) && (w_dy < 11'(OBJECT_HEIGHT));

  always_ff @(posedge clk) begin
    if (resetN) begin
      r_inside <= 1'b0;
      r_off_x  <= '0;
      r_off_y  <= '0;
    end else begin
      r_inside <= w_inside;
      r_off_x  <= w_dx[4:1];
      r_off_y  <= w_dy[4:1];
    end
  end

  assign w_opaque = r_inside && SHIP_BITMAP[r_off_y][r_off_x];

  always_ff @(posedge clk) begin
    if (resetN) begin
      r_draw_request <= 1'b0;
      r_rgb          <= 8'h00;
    end else begin
      r_draw_request <= w_opaque;
      r_rgb          <= w_opaque ? SHIP_RGB : 8'h00;
    end
  end

  assign bus.draw_request = r_draw_request;
  assign bus.RGBout       = r_rgb;
  assign bus.ship_x       = r_top_left_x;

endmodule

// File: tb/tb_player_ship_object.sv
// Directed bench for player_ship_object: reset, drawing, transparency, movement,
// clamping at both edges, vertical boundaries and mid-line reset.
module tb_player_ship_object;

  logic clk;
  logic resetN;
  int   passed;
  int   total;

  player_ship_object_if bus   ();
  player_ship_object_if bus_l ();
  player_ship_object_if bus_r ();

  player_ship_object dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  player_ship_object #(.INITIAL_X(1)) dut_l (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus_l.slave)
  );

  player_ship_object #(.INITIAL_X(607)) dut_r (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus_r.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one pixel and waits out the two-cycle pipeline latency.
  task automatic probe(input logic [10:0] x, input logic [10:0] y);
    bus.pixelX = x;
    bus.pixelY = y;
    step();
    step();
  endtask

  task automatic test_reset();
    resetN = 1'b1;
    step();
    step();
    resetN = 1'b0;
    total++;
    if (bus.ship_x !== 11'd304)
      $display("FAIL reset_ship_x: got %0d expected 304", bus.ship_x);
    else passed++;
    total++;
    if (bus.draw_request !== 1'b0 || bus.RGBout !== 8'h00)
      $display("FAIL reset_outputs: got dr=%b rgb=%h expected dr=0 rgb=00", bus.draw_request, bus.RGBout);
    else passed++;
  endtask

  task automatic test_static_draw();
    probe(11'd0, 11'd0);
    bus.pixelX = 11'd304;
    bus.pixelY = 11'd440;
    step();
    total++;
    if (bus.draw_request !== 1'b0)
      $display("FAIL latency_one_cycle: got dr=%b expected 0", bus.draw_request);
    else passed++;
    step();
    total++;
    if (bus.draw_request !== 1'b1 || bus.RGBout !== 8'h1C)
      $display("FAIL draw_top_left: got dr=%b rgb=%h expected dr=1 rgb=1c", bus.draw_request, bus.RGBout);
    else passed++;
    probe(11'd303, 11'd440);
    total++;
    if (bus.draw_request !== 1'b0 || bus.RGBout !== 8'h00)
      $display("FAIL left_of_box: got dr=%b rgb=%h expected dr=0 rgb=00", bus.draw_request, bus.RGBout);
    else passed++;
    probe(11'd336, 11'd440);
    total++;
    if (bus.draw_request !== 1'b0)
      $display("FAIL right_of_box: got dr=%b expected 0", bus.draw_request);
    else passed++;
    // Last column of row 0 is opaque.
    probe(11'd335, 11'd440);
    total++;
    if (bus.draw_request !== 1'b1 || bus.RGBout !== 8'h1C)
      $display("FAIL last_column: got dr=%b rgb=%h expected dr=1 rgb=1c", bus.draw_request, bus.RGBout);
    else passed++;
  endtask

  task automatic test_transparency();
    probe(11'd306, 11'd440);
    total++;
    if (bus.draw_request !== 1'b0 || bus.RGBout !== 8'h00)
      $display("FAIL transparent_306_440: got dr=%b rgb=%h expected dr=0 rgb=00", bus.draw_request, bus.RGBout);
    else passed++;
    probe(11'd307, 11'd441);
    total++;
    if (bus.draw_request !== 1'b0)
      $display("FAIL transparent_307_441: got dr=%b expected 0", bus.draw_request);
    else passed++;
    probe(11'd305, 11'd441);
    total++;
    if (bus.draw_request !== 1'b1 || bus.RGBout !== 8'h1C)
      $display("FAIL scaled_305_441: got dr=%b rgb=%h expected dr=1 rgb=1c", bus.draw_request, bus.RGBout);
    else passed++;
  endtask

  task automatic test_movement();
    logic [10:0] expect_x;
    expect_x = 11'd304;
    bus.move_right = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (bus.ship_x !== expect_x)
        $display("FAIL move_idle_%0d: got %0d expected %0d", i, bus.ship_x, expect_x);
      else passed++;
      bus.startOfFrame = 1'b1;
      step();
      bus.startOfFrame = 1'b0;
      expect_x = expect_x + 11'd2;
      total++;
      if (bus.ship_x !== expect_x)
        $display("FAIL move_right_%0d: got %0d expected %0d", i, bus.ship_x, expect_x);
      else passed++;
    end
    total++;
    if (bus.ship_x !== 11'd314)
      $display("FAIL move_right_total: got %0d expected 314", bus.ship_x);
    else passed++;
    bus.move_left    = 1'b1;
    bus.startOfFrame = 1'b1;
    step();
    bus.startOfFrame = 1'b0;
    total++;
    if (bus.ship_x !== 11'd314)
      $display("FAIL both_held: got %0d expected 314", bus.ship_x);
    else passed++;
    bus.move_left  = 1'b0;
    bus.move_right = 1'b0;
    // Pixel at the new position now draws; the old top-left column does not.
    probe(11'd314, 11'd440);
    total++;
    if (bus.draw_request !== 1'b1)
      $display("FAIL draw_after_move: got dr=%b expected 1", bus.draw_request);
    else passed++;
    probe(11'd304, 11'd440);
    total++;
    if (bus.draw_request !== 1'b0)
      $display("FAIL old_position: got dr=%b expected 0", bus.draw_request);
    else passed++;
  endtask

  task automatic test_clamp();
    total++;
    if (bus_l.ship_x !== 11'd1 || bus_r.ship_x !== 11'd607)
      $display("FAIL clamp_start: got l=%0d r=%0d expected l=1 r=607", bus_l.ship_x, bus_r.ship_x);
    else passed++;
    bus_l.move_left  = 1'b1;
    bus_r.move_right = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_l.startOfFrame = 1'b1;
      bus_r.startOfFrame = 1'b1;
      step();
      bus_l.startOfFrame = 1'b0;
      bus_r.startOfFrame = 1'b0;
      step();
      total++;
      if (bus_l.ship_x !== 11'd0)
        $display("FAIL clamp_left_%0d: got %0d expected 0", i, bus_l.ship_x);
      else passed++;
      total++;
      if (bus_r.ship_x !== 11'd608)
        $display("FAIL clamp_right_%0d: got %0d expected 608", i, bus_r.ship_x);
      else passed++;
    end
  endtask

  task automatic test_boundary_and_reset();
    logic [10:0] xs [3];
    xs[0] = 11'd0;
    xs[1] = 11'd320;
    xs[2] = 11'd639;
    for (int i = 0; i < 3; i++) begin
      probe(xs[i], 11'd439);
      total++;
      if (bus.draw_request !== 1'b0)
        $display("FAIL above_box_x%0d: got dr=%b expected 0", xs[i], bus.draw_request);
      else passed++;
      probe(xs[i], 11'd472);
      total++;
      if (bus.draw_request !== 1'b0)
        $display("FAIL below_box_x%0d: got dr=%b expected 0", xs[i], bus.draw_request);
      else passed++;
    end
    // Bottom row, column 0 of the bitmap is opaque.
    probe(11'd314, 11'd471);
    total++;
    if (bus.draw_request !== 1'b1)
      $display("FAIL bottom_row: got dr=%b expected 1", bus.draw_request);
    else passed++;
    total++;
    if (bus.draw_request !== 1'b1 || bus.ship_x !== 11'd314)
      $display("FAIL pre_reset_drawing: got dr=%b x=%0d expected dr=1 x=314", bus.draw_request, bus.ship_x);
    else passed++;
    resetN = 1'b1;
    step();
    total++;
    if (bus.draw_request !== 1'b0 || bus.RGBout !== 8'h00)
      $display("FAIL midline_reset_outputs: got dr=%b rgb=%h expected dr=0 rgb=00", bus.draw_request, bus.RGBout);
    else passed++;
    total++;
    if (bus.ship_x !== 11'd304)
      $display("FAIL midline_reset_ship_x: got %0d expected 304", bus.ship_x);
    else passed++;
    resetN = 1'b0;
    step();
    total++;
    if (bus.draw_request !== 1'b0)
      $display("FAIL pipeline_flushed: got dr=%b expected 0", bus.draw_request);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    resetN = 1'b1;
    bus.pixelX = '0;  bus.pixelY = '0;  bus.startOfFrame = 1'b0;
    bus.move_left = 1'b0;  bus.move_right = 1'b0;
    bus_l.pixelX = '0; bus_l.pixelY = '0; bus_l.startOfFrame = 1'b0;
    bus_l.move_left = 1'b0; bus_l.move_right = 1'b0;
    bus_r.pixelX = '0; bus_r.pixelY = '0; bus_r.startOfFrame = 1'b0;
    bus_r.move_left = 1'b0; bus_r.move_right = 1'b0;

    test_reset();
    test_static_draw();
    test_transparency();
    test_movement();
    test_clamp();
    test_boundary_and_reset();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
